arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised, registered N-channel multiplexer with valid/ready handshaking and built-in arbitration. It is the next generation of the pipeline's 2:1 and 3:1 selectors: instead of an externally driven `sel`, it picks among requesting channels by fixed-priority or round-robin rules. The selected word is registered into a one-entry output stage. It sits between multiple producers (for example L1 I-side and D-side miss paths) and a single consumer (for example the L2 request port).

## Interface
- `N_CH`, default 4: number of input channels, 2..16.
- `WIDTH`, default 32: data width per channel.
- `MODE`, default 1: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.
- `SEL_W`, derived: `$clog2(N_CH)`, minimum 1.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input N_CH: per-channel request.
- `in_data` input N_CH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_last` input N_CH: per-channel last beat. Present only with `ARB_MUX_LOCK_EN`.
- `in_ready` output N_CH: one-hot or zero; bit k is high when channel k's beat is accepted this cycle.
- `out_valid` output 1: output register holds a beat.
- `out_data` output WIDTH: registered data.
- `out_sel` output SEL_W: index of the channel that supplied `out_data`.
- `out_ready` input 1: consumer accepts the beat.

## Operation
- Stage can accept a beat when: `can_load = !out_valid || out_ready`.
- Grant:
  - Computed combinationally from `in_valid` every cycle.
  - `in_ready[k] = can_load && grant[k]`.
  - At most one bit of `in_ready` is high at a time.
- Transfer on channel k: `in_valid[k] && in_ready[k]`. On that edge, the stage loads `out_data`, sets `out_sel = k`, and sets `out_valid = 1`.
- Drain: when `out_valid && out_ready` and no new transfer occurs, clear `out_valid` on that edge. `out_data` and `out_sel` hold their last values.
- MODE 0: grant goes to the lowest-index valid channel.
- MODE 1 (round-robin):
  - Pointer `rr_ptr` (SEL_W bits) gives the highest priority to channel `rr_ptr`, then `rr_ptr+1`, and so on, wrapping modulo N_CH.
  - After a transfer from channel k, `rr_ptr` becomes (k+1) mod N_CH. For non-power-of-two N_CH, wrap explicitly: N_CH-1 goes to 0.
  - `rr_ptr` does not change on cycles with no transfer.
- No valid channels: grant is zero and `in_ready` is all-zero.
- Producers must hold `in_data` stable while `in_valid` is high and unaccepted. The block does not check this.

## Timing
- Latency: 1 cycle from the accepting edge to `out_valid`/`out_data`.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, the arbitration state (`rr_ptr`) and, with `ARB_MUX_LOCK_EN`, the lock state.
- Simultaneous drain and load: the new beat replaces the old one and `out_valid` stays 1.
- Backpressure (`out_valid && !out_ready`): all `in_ready` are low, and `out_data`/`out_sel` are held.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `rr_ptr=0`, lock cleared.
- Reset mid-operation drops any held beat. The first post-reset grant follows the reset values of `rr_ptr` and the lock.

## Configuration
- Macro `ARB_MUX_LOCK_EN`.
- Defined:
  - `in_last` port exists.
  - A transfer with `in_last[k]=0` locks the grant to channel k.
  - While locked, only channel k can be granted; other valid channels wait even when k is idle.
  - Lock releases on the edge where k transfers with `in_last[k]=1`.
  - A single-beat transfer (`in_last=1`) never locks.
  - The round-robin pointer advances only on the releasing transfer.
- Undefined: no `in_last` port, no lock state, every beat is arbitrated independently.

## Structure
- Shared package `arb_mux_pkg`:
  - Mode constants `ARB_FIXED=0` and `ARB_RR=1`.
  - Function `sel_width(n)` implementing `$clog2` with a minimum of 1.
- One sub-module, `arb_mux_grant`, is natural:
  - Purely combinational.
  - Inputs: `req`, `rr_ptr`, lock state.
  - Outputs: one-hot `grant` and its encoded index.
- The top module holds the output register, the pointer and the lock flop.

## Test plan
- N_CH=4, MODE 0, `in_valid=4'b1010`, `out_ready=1`: `in_ready=4'b0010`; one cycle later `out_sel=1`, `out_data`=ch1 word. Next cycle (ch1 dropped) grants ch3.
- MODE 1, all four channels valid continuously, `out_ready=1`: `out_sel` sequence is 0,1,2,3,0 with one beat per cycle.
- N_CH=3, MODE 1: pointer wraps 2→0, never reaching 3.
- `out_valid=1`, `out_ready=0` for 3 cycles with ch2 valid:
  - `in_ready=0` throughout and `out_data` unchanged.
  - `out_ready=1`: ch2 is accepted in the same cycle and `out_valid` stays 1.
- `ARB_MUX_LOCK_EN`: ch0 sends 3 beats (last on beat 3) while ch1 is valid throughout. Ch0 has a one-cycle idle gap between beats; ch1 stays ungranted until ch0's last beat, then ch1 is granted.
- Assert `rst_n=0` asynchronously mid-burst (locked, `out_valid=1`): outputs go to 0 immediately without waiting for a clock. After release, MODE 1 grants ch0 first.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux arbitrating multiplexer: arbitration
// mode constants and the select-width helper.
package arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // ceil(log2(n)), never below 1 so a 2-channel mux still has a select bit
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Producer/consumer bundle for arb_mux. slave = the mux, master = the
// surrounding producers and consumer. in_last exists only with ARB_MUX_LOCK_EN.
interface arb_mux_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32
);
  import arb_mux_pkg::*;

  localparam int SEL_W = sel_width(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
`ifdef ARB_MUX_LOCK_EN
  logic [N_CH-1:0]       in_last;
`endif
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;

`ifdef ARB_MUX_LOCK_EN
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/arb_mux_grant.sv
// Combinational arbiter: fixed-priority or round-robin pick among requests,
// optionally restricted to a locked channel. Emits one-hot grant and its index.
module arb_mux_grant
  import arb_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int MODE  = ARB_RR,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic             locked,
  input  logic [SEL_W-1:0] lock_sel,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [SEL_W-1:0] start;
  logic [N_CH-1:0]  eff_req;
  logic [N_CH-1:0]  upper_req;
  logic [SEL_W-1:0] upper_idx;
  logic [SEL_W-1:0] low_idx;
  logic             upper_any;

  assign start = (MODE == ARB_RR) ? rr_ptr : '0;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_req
      assign eff_req[gi]   = req[gi] && (!locked || (lock_sel == SEL_W'(gi)));
      assign upper_req[gi] = eff_req[gi] && (SEL_W'(gi) >= start);
      assign grant[gi]     = grant_any && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    upper_idx = '0;
    low_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (upper_req[i]) upper_idx = SEL_W'(i);
      if (eff_req[i])   low_idx   = SEL_W'(i);
    end
  end

  assign upper_any = |upper_req;
  assign grant_any = |eff_req;
  assign grant_idx = upper_any ? upper_idx : low_idx;

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a one-entry registered output stage.
// Define ARB_MUX_LOCK_EN to hold the grant on a channel until its in_last beat.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  parameter int MODE  = ARB_RR
) (
  input  logic     clk,
  input  logic     rst_n,
  arb_mux_if.slave bus
);

  localparam int SEL_W = sel_width(N_CH);

  logic [SEL_W-1:0] rr_ptr_reg;
  logic [SEL_W-1:0] rr_ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             locked;
  logic [SEL_W-1:0] lock_sel;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             can_load;
  logic             xfer;
  logic             burst_end;
  logic [WIDTH-1:0] ch_data [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  arb_mux_grant #(
    .N_CH  (N_CH),
    .MODE  (MODE),
    .SEL_W (SEL_W)
  ) u_grant (
    .req       (bus.in_valid),
    .rr_ptr    (rr_ptr_reg),
    .locked    (locked),
    .lock_sel  (lock_sel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign can_load     = !out_valid_reg || bus.out_ready;
  assign xfer         = can_load && grant_any;
  assign bus.in_ready = can_load ? grant : '0;

`ifdef ARB_MUX_LOCK_EN
  logic             locked_reg;
  logic [SEL_W-1:0] lock_sel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_reg   <= 1'b0;
      lock_sel_reg <= '0;
    end else if (xfer) begin
      locked_reg   <= !burst_end;
      lock_sel_reg <= grant_idx;
    end
  end

  assign locked    = locked_reg;
  assign lock_sel  = lock_sel_reg;
  assign burst_end = bus.in_last[grant_idx];
`else
  assign locked    = 1'b0;
  assign lock_sel  = '0;
  assign burst_end = 1'b1;
`endif

  // Explicit wrap keeps the pointer inside 0..N_CH-1 for non-power-of-two N_CH.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (xfer && burst_end) begin
      rr_ptr_next = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant_idx];
        out_sel_reg   <= grant_idx;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: fixed-priority, round-robin (4 and 3
// channels), backpressure, optional burst lock and asynchronous reset.
module tb_arb_mux;
  import arb_mux_pkg::*;

  typedef struct {
    int          sel;
    logic [31:0] data;
  } exp_t;

`ifdef ARB_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // reference model state for the round-robin instances
  int ptr1  = 0;
  int ptr2  = 0;
  bit lock1 = 1'b0;
  int lsel1 = 0;
  int beat1 [4];
  int beat2 [3];

  always #5 clk = ~clk;

  arb_mux_if #(.N_CH(4), .WIDTH(32)) b0 ();
  arb_mux_if #(.N_CH(4), .WIDTH(32)) b1 ();
  arb_mux_if #(.N_CH(3), .WIDTH(32)) b2 ();

  arb_mux #(.N_CH(4), .WIDTH(32), .MODE(ARB_FIXED)) u_fix (.clk(clk), .rst_n(rst_n), .bus(b0));
  arb_mux #(.N_CH(4), .WIDTH(32), .MODE(ARB_RR))    u_rr4 (.clk(clk), .rst_n(rst_n), .bus(b1));
  arb_mux #(.N_CH(3), .WIDTH(32), .MODE(ARB_RR))    u_rr3 (.clk(clk), .rst_n(rst_n), .bus(b2));

  function automatic logic [31:0] mkw(input int ch, input int beat);
    return 32'hA500_0000 | (32'(ch) << 16) | 32'(beat);
  endfunction

  function automatic logic [15:0] onehot(input int k);
    if (k < 0) return 16'h0;
    return 16'h1 << k;
  endfunction

  // scan channels starting at the priority origin, modulo n
  function automatic int model_pick(input logic [15:0] req, input int n, input int mode,
                                    input int ptr, input bit locked, input int lsel);
    int start;
    int c;
    start = (mode == ARB_RR) ? ptr : 0;
    for (int off = 0; off < n; off++) begin
      c = (start + off) % n;
      if (req[c] && (!locked || c == lsel)) return c;
    end
    return -1;
  endfunction

  task automatic rr1_update(input int k, input bit last);
    if (!LOCK_EN || last) begin
      ptr1  = (k + 1) % 4;
      lock1 = 1'b0;
    end else begin
      lock1 = 1'b1;
      lsel1 = k;
    end
  endtask

  task automatic set_data1();
    for (int i = 0; i < 4; i++) b1.in_data[i*32 +: 32] = mkw(i, beat1[i]);
  endtask

  task automatic set_data2();
    for (int i = 0; i < 3; i++) b2.in_data[i*32 +: 32] = mkw(i, beat2[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    b0.in_valid = '0;
    b1.in_valid = '0;
    b2.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr1  = 0;
    ptr2  = 0;
    lock1 = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b0.in_valid = '0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = '0; b1.in_data = '0; b1.out_ready = 1'b0;
    b2.in_valid = '0; b2.in_data = '0; b2.out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    b0.in_last = '1; b1.in_last = '1; b2.in_last = '1;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.out_data !== 32'h0 || b0.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_fix got v=%b d=%h s=%0d want v=0 d=0 s=0", b0.out_valid, b0.out_data, b0.out_sel);
    end
    checks++;
    if (b1.out_valid !== 1'b0 || b1.out_data !== 32'h0 || b1.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_rr4 got v=%b d=%h s=%0d want v=0 d=0 s=0", b1.out_valid, b1.out_data, b1.out_sel);
    end
    checks++;
    if (b2.out_valid !== 1'b0 || b2.out_data !== 32'h0 || b2.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_rr3 got v=%b d=%h s=%0d want v=0 d=0 s=0", b2.out_valid, b2.out_data, b2.out_sel);
    end
    checks++;
    if (b1.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0000", b1.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    logic [3:0] pat [2] = '{4'b1010, 4'b1000};
    int   k;
    exp_t e;
    for (int i = 0; i < 4; i++) b0.in_data[i*32 +: 32] = mkw(i, 0);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      b0.in_valid  = pat[s];
      b0.out_ready = 1'b1;
      #1;
      k = model_pick(16'(pat[s]), 4, ARB_FIXED, 0, 1'b0, 0);
      checks++;
      if (b0.in_ready !== 4'(onehot(k))) begin
        errors++;
        $display("FAIL fixed_in_ready step %0d got %b want %b", s, b0.in_ready, 4'(onehot(k)));
      end
      e.sel  = k;
      e.data = mkw(k, 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_sel !== 2'(e.sel) || b0.out_data !== e.data) begin
        errors++;
        $display("FAIL fixed_out step %0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 s, b0.out_valid, b0.out_sel, b0.out_data, e.sel, e.data);
      end
      $display("TX fixed sel=%0d data=%h", b0.out_sel, b0.out_data);
    end
    @(negedge clk);
    b0.in_valid = '0;
    #1;
    checks++;
    if (b0.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_idle_ready got %b want 0000", b0.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.out_sel !== 2'd3 || b0.out_data !== mkw(3, 0)) begin
      errors++;
      $display("FAIL fixed_drain got v=%b s=%0d d=%h want v=0 s=3 d=%h",
               b0.out_valid, b0.out_sel, b0.out_data, mkw(3, 0));
    end
  endtask

  task automatic test_rr();
    logic [3:0] pat [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'h9, 4'h0};
    int   k;
    exp_t e;
`ifdef ARB_MUX_LOCK_EN
    b1.in_last = '1;
`endif
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      set_data1();
      b1.in_valid  = pat[s];
      b1.out_ready = 1'b1;
      #1;
      k = model_pick(16'(pat[s]), 4, ARB_RR, ptr1, lock1, lsel1);
      checks++;
      if (b1.in_ready !== 4'(onehot(k))) begin
        errors++;
        $display("FAIL rr_in_ready step %0d got %b want %b", s, b1.in_ready, 4'(onehot(k)));
      end
      if (k >= 0) begin
        e.sel  = k;
        e.data = mkw(k, beat1[k]);
        sb.push_back(e);
        beat1[k]++;
        rr1_update(k, 1'b1);
      end
      @(posedge clk);
      #1;
      if (k >= 0) begin
        e = sb.pop_front();
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(e.sel) || b1.out_data !== e.data) begin
          errors++;
          $display("FAIL rr_out step %0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                   s, b1.out_valid, b1.out_sel, b1.out_data, e.sel, e.data);
        end
        $display("TX rr4 sel=%0d data=%h", b1.out_sel, b1.out_data);
      end else begin
        checks++;
        if (b1.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rr_drain step %0d got v=%b want v=0", s, b1.out_valid);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] pat [9] = '{3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h7, 3'h5, 3'h5};
    int   k;
    exp_t e;
`ifdef ARB_MUX_LOCK_EN
    b2.in_last = '1;
`endif
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      set_data2();
      b2.in_valid  = pat[s];
      b2.out_ready = 1'b1;
      #1;
      k = model_pick(16'(pat[s]), 3, ARB_RR, ptr2, 1'b0, 0);
      checks++;
      if (b2.in_ready !== 3'(onehot(k))) begin
        errors++;
        $display("FAIL wrap_in_ready step %0d got %b want %b", s, b2.in_ready, 3'(onehot(k)));
      end
      e.sel  = k;
      e.data = mkw(k, beat2[k]);
      sb.push_back(e);
      beat2[k]++;
      ptr2 = (k + 1) % 3;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (b2.out_valid !== 1'b1 || b2.out_sel !== 2'(e.sel) || b2.out_data !== e.data) begin
        errors++;
        $display("FAIL wrap_out step %0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 s, b2.out_valid, b2.out_sel, b2.out_data, e.sel, e.data);
      end
      $display("TX rr3 sel=%0d data=%h", b2.out_sel, b2.out_data);
    end
    @(negedge clk);
    b2.in_valid = '0;
  endtask

  task automatic test_backpressure();
    int   k;
    exp_t e;
    exp_t held;
    @(negedge clk);
    set_data1();
    b1.in_valid  = 4'b0001;
    b1.out_ready = 1'b1;
    #1;
    k = model_pick(16'h0001, 4, ARB_RR, ptr1, lock1, lsel1);
    e.sel  = k;
    e.data = mkw(k, beat1[k]);
    sb.push_back(e);
    beat1[k]++;
    rr1_update(k, 1'b1);
    @(posedge clk);
    #1;
    held = sb.pop_front();
    checks++;
    if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(held.sel) || b1.out_data !== held.data) begin
      errors++;
      $display("FAIL bp_load got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
               b1.out_valid, b1.out_sel, b1.out_data, held.sel, held.data);
    end
    $display("TX bp sel=%0d data=%h", b1.out_sel, b1.out_data);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_data1();
      b1.in_valid  = 4'b0100;
      b1.out_ready = 1'b0;
      #1;
      checks++;
      if (b1.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_stall_ready cycle %0d got %b want 0000", c, b1.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(held.sel) || b1.out_data !== held.data) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 c, b1.out_valid, b1.out_sel, b1.out_data, held.sel, held.data);
      end
    end
    @(negedge clk);
    b1.out_ready = 1'b1;
    #1;
    k = model_pick(16'h0004, 4, ARB_RR, ptr1, lock1, lsel1);
    checks++;
    if (b1.in_ready !== 4'(onehot(k))) begin
      errors++;
      $display("FAIL bp_release_ready got %b want %b", b1.in_ready, 4'(onehot(k)));
    end
    e.sel  = k;
    e.data = mkw(k, beat1[k]);
    sb.push_back(e);
    beat1[k]++;
    rr1_update(k, 1'b1);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(e.sel) || b1.out_data !== e.data) begin
      errors++;
      $display("FAIL bp_release_out got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
               b1.out_valid, b1.out_sel, b1.out_data, e.sel, e.data);
    end
    $display("TX bp sel=%0d data=%h", b1.out_sel, b1.out_data);
    @(negedge clk);
    b1.in_valid = '0;
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    logic [3:0] pat [6] = '{4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
    logic [3:0] lst [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    logic [3:0] lv;
    int   k;
    exp_t e;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      set_data1();
      b1.in_valid  = pat[s];
      b1.in_last   = lst[s];
      b1.out_ready = 1'b1;
      lv = lst[s];
      #1;
      k = model_pick(16'(pat[s]), 4, ARB_RR, ptr1, lock1, lsel1);
      checks++;
      if (b1.in_ready !== 4'(onehot(k))) begin
        errors++;
        $display("FAIL lock_in_ready step %0d got %b want %b", s, b1.in_ready, 4'(onehot(k)));
      end
      if (k >= 0) begin
        e.sel  = k;
        e.data = mkw(k, beat1[k]);
        sb.push_back(e);
        beat1[k]++;
        rr1_update(k, lv[k]);
      end
      @(posedge clk);
      #1;
      if (k >= 0) begin
        e = sb.pop_front();
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(e.sel) || b1.out_data !== e.data) begin
          errors++;
          $display("FAIL lock_out step %0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                   s, b1.out_valid, b1.out_sel, b1.out_data, e.sel, e.data);
        end
        $display("TX lock sel=%0d data=%h", b1.out_sel, b1.out_data);
      end else begin
        checks++;
        if (b1.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL lock_wait step %0d got v=%b want v=0", s, b1.out_valid);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    int   k;
    exp_t e;
    @(negedge clk);
    set_data1();
    b1.in_valid  = 4'b0100;
    b1.out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
    b1.in_last = 4'b0000;
`endif
    #1;
    k = model_pick(16'h0004, 4, ARB_RR, ptr1, lock1, lsel1);
    checks++;
    if (b1.in_ready !== 4'(onehot(k))) begin
      errors++;
      $display("FAIL ar_pre_ready got %b want %b", b1.in_ready, 4'(onehot(k)));
    end
    e.sel  = k;
    e.data = mkw(k, beat1[k]);
    sb.push_back(e);
    beat1[k]++;
    rr1_update(k, 1'b0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(e.sel) || b1.out_data !== e.data) begin
      errors++;
      $display("FAIL ar_pre_out got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
               b1.out_valid, b1.out_sel, b1.out_data, e.sel, e.data);
    end
    $display("TX ar sel=%0d data=%h", b1.out_sel, b1.out_data);
    // reset lands between clock edges
    @(negedge clk);
    b1.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b1.out_valid !== 1'b0 || b1.out_data !== 32'h0 || b1.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL ar_clear_rr4 got v=%b d=%h s=%0d want v=0 d=0 s=0", b1.out_valid, b1.out_data, b1.out_sel);
    end
    checks++;
    if (b0.out_valid !== 1'b0 || b0.out_data !== 32'h0 || b0.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL ar_clear_fix got v=%b d=%h s=%0d want v=0 d=0 s=0", b0.out_valid, b0.out_data, b0.out_sel);
    end
    b1.in_valid  = 4'b1111;
    b1.out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
    b1.in_last = 4'b1111;
`endif
    set_data1();
    @(negedge clk);
    rst_n = 1'b1;
    ptr1  = 0;
    lock1 = 1'b0;
    sb.delete();
    #1;
    k = model_pick(16'h000F, 4, ARB_RR, ptr1, lock1, lsel1);
    checks++;
    if (b1.in_ready !== 4'(onehot(k))) begin
      errors++;
      $display("FAIL ar_first_grant got %b want %b", b1.in_ready, 4'(onehot(k)));
    end
    e.sel  = k;
    e.data = mkw(k, beat1[k]);
    sb.push_back(e);
    beat1[k]++;
    rr1_update(k, 1'b1);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'(e.sel) || b1.out_data !== e.data) begin
      errors++;
      $display("FAIL ar_first_out got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
               b1.out_valid, b1.out_sel, b1.out_data, e.sel, e.data);
    end
    $display("TX ar sel=%0d data=%h", b1.out_sel, b1.out_data);
    @(negedge clk);
    b1.in_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) beat1[i] = 0;
    for (int i = 0; i < 3; i++) beat2[i] = 0;
    test_reset();
    test_fixed();
    test_rr();
    test_wrap();
    test_backpressure();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
